// File: rtl/maxpool_blk_pkg.sv
// Shared types and helpers for the 2x2 stride-2 max-pooling stage.
// Optional build macro: MAXPOOL_RELU_EN (fused ReLU ahead of pooling).
package maxpool_blk_pkg;

  // Row-phase of the pooling walk through one conv output frame.
  typedef enum logic [1:0] {
    ROW_EVEN = 2'd0,  // first row of a pooled pair: fill the line buffer
    ROW_ODD  = 2'd1,  // second row of a pair: compare against line buffer, emit
    ROW_SKIP = 2'd2,  // trailing unpaired row of an odd-sized map: discard
    FULL     = 2'd3   // frame complete: wait for the next start
  } pool_state_t;

  localparam int DEF_OUT_SIZE = 4;
  localparam int DEF_DATA_W   = 48;

  // Conv output side for a given feature map / kernel / padding / stride.
  function automatic int conv_out_size(input int fm_size, input int kernel_size,
                                       input int padding, input int stride);
    return ((fm_size - kernel_size + 2 * padding) / stride) + 1;
  endfunction

  // Ceiling log2, never below 1 so that counters always have a bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/maxpool_blk_pool_line_buf.sv
// Line buffer holding the horizontal maxima of the even row of a pooled pair.
// One synchronous write port, one combinational read port, cleared on reset.
module pool_line_buf #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 48,
  parameter int AW     = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_waddr,
  input  logic signed [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]            i_raddr,
  output logic signed [DATA_W-1:0] o_rdata
);

  logic signed [DATA_W-1:0] r_mem [DEPTH];

  // Storage: cleared on reset, written one entry per completed horizontal pair.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read is combinational so the odd row can compare in the same cycle.
  always_comb begin
    o_rdata = r_mem[i_raddr];
  end

endmodule

// File: rtl/maxpool_blk.sv
// 2x2 stride-2 max pooling over a raster-order conv result stream.
// Optional build macro: MAXPOOL_RELU_EN -- negative samples are forced to 0
// before pooling, so every pooled output is non-negative.
//
// Stream protocol: i_en is a valid-only strobe (no ready, the stage always
// accepts); o_en is a one-cycle valid pulse per pooled pixel and o_done is
// raised together with the o_en of the last pooled pixel of the frame.
module maxpool_blk
  import maxpool_blk_pkg::*;
#(
  parameter int OUT_SIZE = DEF_OUT_SIZE,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_en,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_done,
  output pool_state_t              o_dbg_state
);

  localparam int POOL_SIZE = OUT_SIZE / 2;
  localparam int CW        = clog2_min1(OUT_SIZE);
  localparam int AW        = clog2_min1(POOL_SIZE);
  localparam logic [CW-1:0] COL_LAST  = CW'(OUT_SIZE - 1);
  localparam logic [CW-1:0] POOL_LAST = CW'(2 * POOL_SIZE - 1);
  localparam bit ODD_SIZE = (OUT_SIZE % 2) == 1;

  logic [CW-1:0]            r_col;
  logic [CW-1:0]            r_row;
  pool_state_t              r_state;
  logic signed [DATA_W-1:0] r_h;
  logic                     r_en;
  logic signed [DATA_W-1:0] r_data;
  logic                     r_done;

  logic [CW-1:0]            w_col;
  logic [CW-1:0]            w_row;
  pool_state_t              w_state;
  logic                     w_take;
  logic                     w_trail;
  logic signed [DATA_W-1:0] w_sample;
  logic signed [DATA_W-1:0] w_h;
  logic signed [DATA_W-1:0] w_lb_rdata;
  logic signed [DATA_W-1:0] w_pool;
  logic                     w_lb_we;
  logic [AW-1:0]            w_idx;

  // Optional fused ReLU on the incoming sample.
  always_comb begin
`ifdef MAXPOOL_RELU_EN
    w_sample = i_data[DATA_W-1] ? '0 : i_data;
`else
    w_sample = i_data;
`endif
  end

  // Effective position: a start pulse re-homes the walk before this cycle's sample is used.
  always_comb begin
    w_col   = i_start ? '0 : r_col;
    w_row   = i_start ? '0 : r_row;
    w_state = i_start ? ROW_EVEN : r_state;
    w_take  = i_en && (i_start || (r_state != FULL));
    w_trail = ODD_SIZE && (w_col == COL_LAST);
    w_idx   = AW'(w_col >> 1);
  end

  // Horizontal and vertical maxima plus line-buffer write enable.
  always_comb begin
    w_h     = (r_h > w_sample) ? r_h : w_sample;
    w_pool  = (w_lb_rdata > w_h) ? w_lb_rdata : w_h;
    w_lb_we = w_take && (w_state == ROW_EVEN) && w_col[0];
  end

  pool_line_buf #(
    .DEPTH  (POOL_SIZE),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_line_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_lb_we),
    .i_waddr (w_idx),
    .i_wdata (w_h),
    .i_raddr (w_idx),
    .o_rdata (w_lb_rdata)
  );

  // Walk FSM, counters, horizontal hold register and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_state <= ROW_EVEN;
      r_h     <= '0;
      r_en    <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_en   <= 1'b0;
      r_done <= 1'b0;
      if (w_take) begin
        r_col   <= w_col;
        r_row   <= w_row;
        r_state <= w_state;
        // Even column opens a horizontal pair; trailing column and skipped rows are dropped.
        if (!w_col[0] && !w_trail && (w_state != ROW_SKIP)) begin
          r_h <= w_sample;
        end
        if ((w_state == ROW_ODD) && w_col[0]) begin
          r_data <= w_pool;
          r_en   <= 1'b1;
          r_done <= (w_row == POOL_LAST) && (w_col == POOL_LAST);
        end
        if (w_col == COL_LAST) begin
          r_col <= '0;
          case (w_state)
            ROW_EVEN: begin
              r_row   <= w_row + 1'b1;
              r_state <= ROW_ODD;
            end
            ROW_ODD: begin
              if (w_row == POOL_LAST) begin
                r_row   <= ODD_SIZE ? (w_row + 1'b1) : '0;
                r_state <= ODD_SIZE ? ROW_SKIP : FULL;
              end else begin
                r_row   <= w_row + 1'b1;
                r_state <= ROW_EVEN;
              end
            end
            ROW_SKIP: begin
              r_row   <= '0;
              r_state <= FULL;
            end
            default: begin
              r_row   <= w_row;
              r_state <= w_state;
            end
          endcase
        end else begin
          r_col <= w_col + 1'b1;
        end
      end else if (i_start) begin
        r_col   <= '0;
        r_row   <= '0;
        r_state <= ROW_EVEN;
      end
    end
  end

  assign o_en        = r_en;
  assign o_data      = r_data;
  assign o_done      = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_maxpool_blk.sv
// Bench for maxpool_blk: a 4x4 and a 5x5 instance, directed and random frames
// checked against a block-maximum reference model.
module tb_maxpool_blk;
  import maxpool_blk_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                a_start, a_en, a_oen, a_done;
  logic signed [W-1:0] a_data, a_odata;
  pool_state_t         a_state;
  logic                b_start, b_en, b_oen, b_done;
  logic signed [W-1:0] b_data, b_odata;
  pool_state_t         b_state;

  maxpool_blk #(.OUT_SIZE(4), .DATA_W(W)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_en(a_en), .i_data(a_data),
    .o_en(a_oen), .o_data(a_odata), .o_done(a_done), .o_dbg_state(a_state)
  );

  maxpool_blk #(.OUT_SIZE(5), .DATA_W(W)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_en(b_en), .i_data(b_data),
    .o_en(b_oen), .o_data(b_odata), .o_done(b_done), .o_dbg_state(b_state)
  );

  int total = 0;
  int bad   = 0;

  logic signed [W-1:0] frm [2][25];
  logic signed [W-1:0] a_got_q[$], b_got_q[$];
  bit                  a_dq[$], b_dq[$];
  int                  a_done_cnt = 0, b_done_cnt = 0;

  // Output capture on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (a_oen) begin a_got_q.push_back(a_odata); a_dq.push_back(a_done); end
    if (b_oen) begin b_got_q.push_back(b_odata); b_dq.push_back(b_done); end
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_caps();
    a_got_q.delete(); b_got_q.delete(); a_dq.delete(); b_dq.delete();
    a_done_cnt = 0; b_done_cnt = 0;
  endtask

  function automatic logic signed [W-1:0] relu(input logic signed [W-1:0] v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: each pooled pixel is the max of its 2x2 block; odd leftovers ignored.
  task automatic check_frame(input int sel, input string tag);
    logic signed [W-1:0] exp_q[$];
    logic signed [W-1:0] got_q[$];
    bit                  dq[$];
    int                  dcnt, n, p;
    logic signed [W-1:0] m, v;
    n = (sel == 0) ? 4 : 5;
    p = n / 2;
    if (sel == 0) begin got_q = a_got_q; dq = a_dq; dcnt = a_done_cnt; end
    else          begin got_q = b_got_q; dq = b_dq; dcnt = b_done_cnt; end
    for (int pr = 0; pr < p; pr++) begin
      for (int pc = 0; pc < p; pc++) begin
        m = relu(frm[sel][(2 * pr) * n + 2 * pc]);
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            v = relu(frm[sel][(2 * pr + dr) * n + 2 * pc + dc]);
            if (v > m) m = v;
          end
        end
        exp_q.push_back(m);
      end
    end
    chk({tag, ".count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s.px%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
      chk($sformatf("%s.done%0d", tag, i), int'(dq[i]), (i == exp_q.size() - 1) ? 1 : 0);
    end
    chk({tag, ".done_cnt"}, dcnt, 1);
  endtask

  // Directed spot check of one captured output of instance A or B.
  task automatic chk_px(input int sel, input string tag, input int idx, input int exp);
    int got;
    got = -99999;
    if (sel == 0) begin if (idx < a_got_q.size()) got = int'(a_got_q[idx]); end
    else          begin if (idx < b_got_q.size()) got = int'(b_got_q[idx]); end
    chk($sformatf("%s.direct%0d", tag, idx), got, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic cyc(input int sel, input bit s, input bit e, input logic signed [W-1:0] d);
    if (sel == 0) begin a_start = s; a_en = e; a_data = d; end
    else          begin b_start = s; b_en = e; b_data = d; end
    @(posedge clk); #1;
    a_start = 1'b0; a_en = 1'b0; b_start = 1'b0; b_en = 1'b0;
  endtask

  task automatic run_frame(input int sel, input int gap_max, input bit start_with_en);
    int n, first;
    n = (sel == 0) ? 4 : 5;
    clear_caps();
    first = 0;
    if (start_with_en) begin
      cyc(sel, 1'b1, 1'b1, frm[sel][0]);
      first = 1;
    end else begin
      cyc(sel, 1'b1, 1'b0, W'($urandom));
    end
    for (int i = first; i < n * n; i++) begin
      repeat ($urandom_range(0, gap_max)) cyc(sel, 1'b0, 1'b0, W'($urandom));
      cyc(sel, 1'b0, 1'b1, frm[sel][i]);
    end
    repeat (3) cyc(sel, 1'b0, 1'b0, W'($urandom));
  endtask

  task automatic rand_frame(input int sel);
    for (int i = 0; i < 25; i++) frm[sel][i] = W'($urandom);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_en = 1'b0; a_data = '0;
    b_start = 1'b0; b_en = 1'b0; b_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst.a_en",    int'(a_oen),   0);
    chk("rst.a_data",  int'(a_odata), 0);
    chk("rst.a_done",  int'(a_done),  0);
    chk("rst.a_state", int'(a_state), int'(ROW_EVEN));
    chk("rst.b_en",    int'(b_oen),   0);
    chk("rst.b_state", int'(b_state), int'(ROW_EVEN));

    // 4x4 ramp, back to back
    for (int i = 0; i < 25; i++) frm[0][i] = W'(i);
    run_frame(0, 0, 1'b0);
    check_frame(0, "ramp4");
    chk_px(0, "ramp4", 0, 5);
    chk_px(0, "ramp4", 1, 7);
    chk_px(0, "ramp4", 2, 13);
    chk_px(0, "ramp4", 3, 15);
    chk("ramp4.state_full", int'(a_state), int'(FULL));

    // 5x5 ramp: trailing column and row discarded
    for (int i = 0; i < 25; i++) frm[1][i] = W'(i);
    run_frame(1, 0, 1'b0);
    check_frame(1, "ramp5");
    chk_px(1, "ramp5", 0, 6);
    chk_px(1, "ramp5", 1, 8);
    chk_px(1, "ramp5", 2, 16);
    chk_px(1, "ramp5", 3, 18);

    // Negative ramp with random gaps
    for (int i = 0; i < 25; i++) frm[0][i] = W'(-(i + 1));
    run_frame(0, 3, 1'b0);
    check_frame(0, "neg4");
`ifdef MAXPOOL_RELU_EN
    chk_px(0, "neg4", 0, 0);
    chk_px(0, "neg4", 3, 0);
`else
    chk_px(0, "neg4", 0, -1);
    chk_px(0, "neg4", 1, -3);
    chk_px(0, "neg4", 2, -9);
    chk_px(0, "neg4", 3, -11);
`endif

    // Reset in the middle of a frame
    cyc(0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) cyc(0, 1'b0, 1'b1, W'(i));
    rst = 1'b1;
    #1;
    chk("midrst.a_en",    int'(a_oen),   0);
    chk("midrst.a_data",  int'(a_odata), 0);
    chk("midrst.a_state", int'(a_state), int'(ROW_EVEN));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 25; i++) frm[0][i] = W'(i);
    run_frame(0, 0, 1'b0);
    check_frame(0, "midrst");

    // Start and first sample in the same cycle
    frm[0][0] = W'(100);
    for (int i = 1; i < 16; i++) frm[0][i] = W'(i);
    run_frame(0, 0, 1'b1);
    check_frame(0, "startdata");
    chk_px(0, "startdata", 0, 100);

    // Samples after frame end without a start are ignored
    clear_caps();
    for (int i = 0; i < 5; i++) cyc(0, 1'b0, 1'b1, W'($urandom));
    repeat (3) cyc(0, 1'b0, 1'b0, '0);
    chk("postframe.outs",  a_got_q.size(), 0);
    chk("postframe.done",  a_done_cnt, 0);
    chk("postframe.state", int'(a_state), int'(FULL));
    rand_frame(0);
    run_frame(0, 2, 1'b0);
    check_frame(0, "postframe.next");

    // Random frames with random gaps on both sizes
    for (int k = 0; k < 4; k++) begin
      rand_frame(0);
      run_frame(0, 2, ($urandom_range(0, 1) == 1));
      check_frame(0, $sformatf("rand4_%0d", k));
      rand_frame(1);
      run_frame(1, 2, ($urandom_range(0, 1) == 1));
      check_frame(1, $sformatf("rand5_%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
